// File: rtl/chan_counter_bank_pkg.sv
// Shared encodings for the channel counter bank: counting modes,
// per-channel FSM states and ping-pong direction.
package chan_counter_bank_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP     = 2'b00,
    MODE_RELOAD   = 2'b01,
    MODE_ONESHOT  = 2'b10,
    MODE_PINGPONG = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/chan_counter_bank_core.sv
// One counter channel: mode/limit config, count FSM, registered tc pulse
// and sticky irq flag.
module chan_counter_core
  import chan_counter_bank_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             cfg_we_i,
  input  logic [1:0]       cfg_mode_i,
  input  logic [WIDTH-1:0] cfg_limit_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             irq_ack_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o,
  output logic             irq_pend_o,
  output state_e           state_o
);

  mode_e            mode_q, mode_d;
  state_e           state_q, state_d;
  dir_e             dir_q, dir_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic [WIDTH-1:0] eff_limit;
  logic             tc_q, tc_d;
  logic             irq_pend_q, irq_pend_d;
  logic             do_step;

  always_comb begin
    mode_d     = mode_q;
    limit_d    = limit_q;
    dir_d      = dir_q;
    count_d    = count_q;
    state_d    = state_q;
    tc_d       = 1'b0;
    eff_limit  = cfg_we_i ? cfg_limit_i : limit_q;
    do_step    = en_i && !cfg_we_i && !load_i && (state_q != ST_DONE);
    // tc_q is the visible pulse, so an ack in that same cycle cannot win.
    irq_pend_d = (irq_pend_q & ~irq_ack_i) | tc_q;

    if (cfg_we_i) begin
      mode_d  = mode_e'(cfg_mode_i);
      limit_d = cfg_limit_i;
      dir_d   = DIR_UP;
      if (count_q > cfg_limit_i) count_d = cfg_limit_i;
    end
    // Load clamps against the limit that is in force after any same-cycle write.
    if (load_i) count_d = (load_val_i > eff_limit) ? eff_limit : load_val_i;

    if (cfg_we_i || load_i) begin
      state_d = (state_q == ST_DONE || !en_i) ? ST_IDLE : ST_RUN;
    end else if (state_q != ST_DONE) begin
      state_d = en_i ? ST_RUN : ST_IDLE;
    end

    if (do_step) begin
      case (mode_q)
        MODE_WRAP: begin
          if (count_q == limit_q) begin
            count_d = '0;
            tc_d    = 1'b1;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
        MODE_RELOAD: begin
          if (count_q == '0) begin
            count_d = limit_q;
            tc_d    = 1'b1;
          end else begin
            count_d = count_q - 1'b1;
          end
        end
        MODE_ONESHOT: begin
          if (count_q >= limit_q) begin
            tc_d    = 1'b1;
            state_d = ST_DONE;
          end else begin
            count_d = count_q + 1'b1;
            if (count_q == limit_q - 1'b1) begin
              tc_d    = 1'b1;
              state_d = ST_DONE;
            end
          end
        end
        MODE_PINGPONG: begin
          if (limit_q == '0) begin
            tc_d = 1'b1;
          end else if (dir_q == DIR_UP) begin
            if (count_q >= limit_q) begin
              count_d = count_q - 1'b1;
              dir_d   = DIR_DOWN;
            end else begin
              count_d = count_q + 1'b1;
              tc_d    = (count_q == limit_q - 1'b1);
            end
          end else begin
            if (count_q == '0) begin
              count_d = count_q + 1'b1;
              dir_d   = DIR_UP;
              tc_d    = (limit_q == WIDTH'(1));
            end else begin
              count_d = count_q - 1'b1;
            end
          end
        end
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= MODE_WRAP;
      limit_q    <= '1;
      dir_q      <= DIR_UP;
      count_q    <= '0;
      state_q    <= ST_IDLE;
      tc_q       <= 1'b0;
      irq_pend_q <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      limit_q    <= limit_d;
      dir_q      <= dir_d;
      count_q    <= count_d;
      state_q    <= state_d;
      tc_q       <= tc_d;
      irq_pend_q <= irq_pend_d;
    end
  end

  assign count_o    = count_q;
  assign tc_o       = tc_q;
  assign irq_pend_o = irq_pend_q;
  assign state_o    = state_q;

endmodule

// File: rtl/chan_counter_bank.sv
// Bank of independent counter channels: channel-select decode, count
// packing, irq reduction and per-channel FSM state export.
module chan_counter_bank
  import chan_counter_bank_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int CH_BITS  = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       en,
  input  logic                      cfg_we,
  input  logic [CH_BITS-1:0]        cfg_ch,
  input  logic [1:0]                cfg_mode,
  input  logic [WIDTH-1:0]          cfg_limit,
  input  logic                      load,
  input  logic [WIDTH-1:0]          load_val,
  input  logic [CHANNELS-1:0]       irq_ack,
  output logic [CHANNELS*WIDTH-1:0] count,
  output logic [CHANNELS-1:0]       tc,
  output logic [CHANNELS-1:0]       irq_pend,
  output logic                      irq,
  output logic [2*CHANNELS-1:0]     state_dbg
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic   sel;
    state_e ch_state;

    // Out-of-range channel numbers match no instance and are dropped.
    assign sel = (cfg_ch == CH_BITS'(i));

    chan_counter_core #(.WIDTH(WIDTH)) u_core (
      .clk        (clk),
      .rst_n      (rst_n),
      .en_i       (en[i]),
      .cfg_we_i   (cfg_we & sel),
      .cfg_mode_i (cfg_mode),
      .cfg_limit_i(cfg_limit),
      .load_i     (load & sel),
      .load_val_i (load_val),
      .irq_ack_i  (irq_ack[i]),
      .count_o    (count[i*WIDTH +: WIDTH]),
      .tc_o       (tc[i]),
      .irq_pend_o (irq_pend[i]),
      .state_o    (ch_state)
    );

    assign state_dbg[2*i +: 2] = ch_state;
  end

  assign irq = |irq_pend;

endmodule

// File: doc/chan_counter_bank.md
CHAN_COUNTER_BANK -- requirements
Module: chan_counter_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 8, counter width in bits (2..32).
REQ-002 SHALL have parameter CHANNELS, default 4, number of independent counter channels (1..16).
REQ-003 SHALL have parameter CH_BITS, default 2, channel-select width, >= clog2(CHANNELS).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port en  input  CHANNELS  per-channel count enable.
REQ-007 SHALL have port cfg_we  input  1  config write strobe.
REQ-008 SHALL have port cfg_ch  input  CH_BITS  channel addressed by cfg_we/load.
REQ-009 SHALL have port cfg_mode  input  2  mode: 00 wrap-up, 01 reload-down, 10 one-shot-up, 11 ping-pong.
REQ-010 SHALL have port cfg_limit  input  WIDTH  terminal value for the addressed channel.
REQ-011 SHALL have port load  input  1  load strobe for count of channel cfg_ch.
REQ-012 SHALL have port load_val  input  WIDTH  value written by load.
REQ-013 SHALL have port irq_ack  input  CHANNELS  per-channel clear of the sticky irq bits.
REQ-014 SHALL have port count  output  CHANNELS*WIDTH  packed counts, channel i at bits [i*WIDTH +: WIDTH].
REQ-015 SHALL have port tc  output  CHANNELS  registered one-cycle terminal-count pulse per channel.
REQ-016 SHALL have port irq_pend  output  CHANNELS  sticky terminal-count flags.
REQ-017 SHALL have port irq  output  1  OR of irq_pend.

Function
REQ-018 Per-channel FSM SHALL have states IDLE, RUN, DONE; IDLE->RUN on first cycle en[i]=1; RUN->IDLE when en[i]=0; DONE only in mode 10.
REQ-019 Mode 00: count SHALL increment by 1 per enabled cycle; at count==limit next value is 0 and tc pulses.
REQ-020 Mode 01: count SHALL decrement by 1; at count==0 next value is limit and tc pulses.
REQ-021 Mode 10: count SHALL increment to limit, pulse tc once, enter DONE and hold; only load or cfg_we leaves DONE (to IDLE).
REQ-022 Mode 11: direction SHALL flip at count==limit (to down) and count==0 (to up); tc pulses only at limit.
REQ-023 limit==0 SHALL hold count at 0 and pulse tc every enabled cycle in modes 00/01/11; mode 10 enters DONE after one cycle.
REQ-024 load SHALL set count to min(load_val, limit) next cycle, override the count step that cycle, and not pulse tc.
REQ-025 cfg_we and load together to the same channel SHALL apply new mode/limit first, then clamp load_val against the new limit.
REQ-026 cfg_we SHALL NOT alter count except to clamp it to the new limit if it exceeds it; direction resets to up.
REQ-027 cfg_ch >= CHANNELS SHALL be ignored for cfg_we and load.
REQ-028 irq_pend[i] SHALL set on tc[i]; set wins over simultaneous irq_ack[i].
REQ-029 tc SHALL be registered: asserted in the cycle count shows the wrapped/reload/held value.

Reset
REQ-030 rst_n low SHALL asynchronously force count=0, tc=0, irq_pend=0, irq=0, mode=00, limit=all-ones, direction up, state IDLE in every channel.
REQ-031 Reset asserted mid-count SHALL abort immediately; first count step occurs on the first enabled edge after rst_n rises.

Structure
REQ-032 Mode encodings and FSM state encodings SHALL live in a shared package (header) of constants, used by both modules.
REQ-033 One sub-module chan_counter_core (one channel: FSM, count, limit, mode, direction, tc, irq_pend) SHALL be instantiated CHANNELS times via generate.
REQ-034 Top level SHALL contain only cfg_ch decode, packing of count, and the irq OR.

Verification
REQ-035 Mode 00, limit=3, en[0]=1 for 9 cycles -> count0 0,1,2,3,0,1,2,3,0; tc[0] high with both 0s.
REQ-036 Mode 10, limit=5 -> count stops at 5, one tc, state DONE; load 2 -> count=2, IDLE, counting resumes.
REQ-037 Mode 11, limit=2 -> 0,1,2,1,0,1,2; tc only at each 2.
REQ-038 Load load_val=200 with limit=100 -> count=100; same cycle cfg_we limit=50 -> count=50.
REQ-039 tc[1] and irq_ack[1] same cycle -> irq_pend[1] stays 1; ack next cycle -> 0, irq falls.
REQ-040 rst_n pulsed low mid-count (count=7) -> all outputs 0 within the same cycle, limit all-ones after release.
